// File: rtl/mlp_param_loader_pkg.sv
// Shared types and sizing helpers for the MLP parameter loader.
// The stream holds the x vector first, then the biases and weights of each layer in turn.
package mlp_param_loader_pkg;

    localparam int DEF_QM = 3;
    localparam int DEF_QN = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FIRE = 2'd2
    } loader_state_t;

    typedef enum logic [1:0] {
        SEC_X = 2'd0,
        SEC_B = 2'd1,
        SEC_W = 2'd2
    } load_sec_t;

    // Number of words in one configuration stream.
    function automatic int total_words(input int m, input int n);
        return n + (m - 1) * (n + n * n);
    endfunction

    // Counter width for an index range 0..n-1. The result is never less than 1.
    function automatic int idx_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mlp_param_loader_addr_gen.sv
// Walks the stream order (x, then b/w per layer, k fastest) and decodes one-hot write selects.
// o_last flags the final weight of the final layer.
module mlp_param_loader_addr_gen
    import mlp_param_loader_pkg::*;
#(
    parameter int M = 3,
    parameter int N = 3
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_clear,
    input  logic                             i_adv,
    output logic [N-1:0]                     o_sel_x,
    output logic [M-2:0][N-1:0]              o_sel_b,
    output logic [M-2:0][N-1:0][N-1:0]       o_sel_w,
    output logic                             o_last
);

    localparam int CW = idx_bits(N);
    localparam int LW = idx_bits(M - 1);
    localparam logic [CW-1:0] IDX_LAST = CW'(N - 1);
    localparam logic [LW-1:0] LAY_LAST = LW'(M - 2);

    load_sec_t       r_sec;
    logic [LW-1:0]   r_layer;
    logic [CW-1:0]   r_row;
    logic [CW-1:0]   r_col;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sec   <= SEC_X;
            r_layer <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else if (i_clear) begin
            r_sec   <= SEC_X;
            r_layer <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else if (i_adv) begin
            case (r_sec)
                SEC_X: begin
                    if (r_col == IDX_LAST) begin
                        r_sec <= SEC_B;
                        r_col <= '0;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                SEC_B: begin
                    if (r_col == IDX_LAST) begin
                        r_sec <= SEC_W;
                        r_col <= '0;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                SEC_W: begin
                    if (r_col != IDX_LAST) begin
                        r_col <= r_col + 1'b1;
                    end else begin
                        r_col <= '0;
                        if (r_row != IDX_LAST) begin
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_row <= '0;
                            // The last layer stays put; the loader leaves LOAD on o_last.
                            if (r_layer != LAY_LAST) begin
                                r_layer <= r_layer + 1'b1;
                                r_sec   <= SEC_B;
                            end
                        end
                    end
                end
                default: r_sec <= SEC_X;
            endcase
        end
    end

    always_comb begin
        o_sel_x = '0;
        o_sel_b = '0;
        o_sel_w = '0;
        for (int j = 0; j < N; j++) begin
            if (r_sec == SEC_X && r_col == CW'(j)) o_sel_x[j] = 1'b1;
            for (int l = 0; l < M - 1; l++) begin
                if (r_sec == SEC_B && r_layer == LW'(l) && r_col == CW'(j))
                    o_sel_b[l][j] = 1'b1;
                for (int k = 0; k < N; k++) begin
                    if (r_sec == SEC_W && r_layer == LW'(l) && r_row == CW'(j) && r_col == CW'(k))
                        o_sel_w[l][j][k] = 1'b1;
                end
            end
        end
    end

    assign o_last = (r_sec == SEC_W) && (r_layer == LAY_LAST) &&
                    (r_row == IDX_LAST) && (r_col == IDX_LAST);

endmodule

// File: rtl/mlp_param_loader.sv
// Loads x/b/w for the MLP from a valid/ready word stream, then pulses init for one cycle.
// Handshake: a word moves on a cycle with i_in_valid && o_in_ready; o_in_ready depends only on state.
module mlp_param_loader
    import mlp_param_loader_pkg::*;
#(
    parameter int M  = 3,
    parameter int N  = 3,
    parameter int QM = DEF_QM,
    parameter int QN = DEF_QN,
    parameter int WM = 3,
    parameter int WN = 5,
    localparam int W = QM + QN
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_start,
    input  logic                              i_in_valid,
    output logic                              o_in_ready,
    input  logic [W-1:0]                      i_in_data,
    output logic [N-1:0][W-1:0]               o_x,
    output logic [M-2:0][N-1:0][W-1:0]        o_b,
    output logic [M-2:0][N-1:0][N-1:0][W-1:0] o_w,
    output logic                              o_init,
    output logic                              o_initial_flag,
    output logic                              o_weight_flag,
    output logic                              o_busy,
    output logic                              o_done,
    output loader_state_t                     o_state
);

    if (WM != QM || WN != QN) begin : g_fmt_check
        $error("mlp_param_loader: weight Q format must equal data Q format");
    end

    loader_state_t                     r_state;
    loader_state_t                     w_state_nxt;
    logic                              w_ready;
    logic                              w_fire;
    logic                              w_xfer;
    logic                              w_clear;
    logic                              w_last;
    logic [N-1:0]                      w_sel_x;
    logic [M-2:0][N-1:0]               w_sel_b;
    logic [M-2:0][N-1:0][N-1:0]        w_sel_w;
    logic [N-1:0][W-1:0]               r_x;
    logic [M-2:0][N-1:0][W-1:0]        r_b;
    logic [M-2:0][N-1:0][N-1:0][W-1:0] r_w;

    assign w_xfer  = i_in_valid && w_ready;
    assign w_clear = (r_state == S_IDLE) && i_start;

    mlp_param_loader_addr_gen #(.M(M), .N(N)) u_addr_gen (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_clear),
        .i_adv   (w_xfer),
        .o_sel_x (w_sel_x),
        .o_sel_b (w_sel_b),
        .o_sel_w (w_sel_w),
        .o_last  (w_last)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_fire      = 1'b0;
        case (r_state)
            S_IDLE: if (i_start) w_state_nxt = S_LOAD;
            S_LOAD: begin
                w_ready = 1'b1;
                if (w_xfer && w_last) w_state_nxt = S_FIRE;
            end
            S_FIRE: begin
                w_fire      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Entries are overwritten in place; untouched entries keep the previous load.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x <= '0;
            r_b <= '0;
            r_w <= '0;
        end else if (w_xfer) begin
            for (int j = 0; j < N; j++) begin
                if (w_sel_x[j]) r_x[j] <= i_in_data;
                for (int l = 0; l < M - 1; l++) begin
                    if (w_sel_b[l][j]) r_b[l][j] <= i_in_data;
                    for (int k = 0; k < N; k++) begin
                        if (w_sel_w[l][j][k]) r_w[l][j][k] <= i_in_data;
                    end
                end
            end
        end
    end

    assign o_in_ready     = w_ready;
    assign o_init         = w_fire;
    assign o_initial_flag = w_fire;
    assign o_weight_flag  = w_fire;
    assign o_done         = w_fire;
    assign o_busy         = (r_state == S_LOAD) || (r_state == S_FIRE);
    assign o_state        = r_state;
    assign o_x            = r_x;
    assign o_b            = r_b;
    assign o_w            = r_w;

endmodule

// File: tb/tb_mlp_param_loader.sv
// Directed bench for mlp_param_loader: streams configurations and scoreboards the unpacked arrays.
module tb_mlp_param_loader;
    import mlp_param_loader_pkg::*;

    localparam int M     = 3;
    localparam int N     = 3;
    localparam int W     = 8;
    localparam int TOTAL = 27;

    logic                              clk = 1'b0;
    logic                              rst;
    logic                              start;
    logic                              in_valid;
    logic                              in_ready;
    logic [W-1:0]                      in_data;
    logic [N-1:0][W-1:0]               x;
    logic [M-2:0][N-1:0][W-1:0]        b;
    logic [M-2:0][N-1:0][N-1:0][W-1:0] w;
    logic                              init;
    logic                              initial_flag;
    logic                              weight_flag;
    logic                              busy;
    logic                              done;
    loader_state_t                     state;

    always #5 clk = ~clk;

    mlp_param_loader #(.M(M), .N(N), .QM(3), .QN(5), .WM(3), .WN(5)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_data      (in_data),
        .o_x            (x),
        .o_b            (b),
        .o_w            (w),
        .o_init         (init),
        .o_initial_flag (initial_flag),
        .o_weight_flag  (weight_flag),
        .o_busy         (busy),
        .o_done         (done),
        .o_state        (state)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         init_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_mem [TOTAL];

    always @(negedge clk) if (init === 1'b1) init_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Flat stream index -> DUT array entry.
    function automatic logic [W-1:0] dut_word(input int idx);
        int r, l, o;
        if (idx < N) return x[idx];
        r = idx - N;
        l = r / (N + N * N);
        o = r % (N + N * N);
        if (o < N) return b[l][o];
        return w[l][(o - N) / N][(o - N) % N];
    endfunction

    function automatic logic [W-1:0] word_of(input int mode, input logic [W-1:0] cval, input int idx);
        if (mode == 0) return W'(idx + 1);
        if (mode == 2) return W'(8'h40 + idx);
        return cval;
    endfunction

    task automatic check_mem(input string tag);
        for (int i = 0; i < TOTAL; i++)
            check($sformatf("%s[%0d]", tag, i), 32'(dut_word(i)), 32'(exp_mem[i]));
    endtask

    task automatic begin_load(input logic hold);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        check("begin_ready", 32'(in_ready), 32'd1);
        check("begin_busy", 32'(busy), 32'd1);
    endtask

    task automatic stream(input int mode, input logic [W-1:0] cval, input int bubble_pct,
                          input int base, input int n, output int cycles);
        int   done_n;
        logic v;
        logic rdy;
        done_n = 0;
        cycles = 0;
        while (done_n < n && cycles < 4000) begin
            @(negedge clk);
            v        = ($urandom_range(0, 99) >= bubble_pct);
            in_valid = v;
            in_data  = word_of(mode, cval, base + done_n);
            rdy      = in_ready;
            @(posedge clk);
            cycles++;
            if (v && rdy) begin
                exp_q.push_back(word_of(mode, cval, base + done_n));
                done_n++;
            end
        end
        #1;
        in_valid = 1'b0;
        check("stream_transfers", 32'(done_n), 32'(n));
    endtask

    task automatic finish_check(input string tag);
        logic [W-1:0] e;
        check({tag, "_init"}, 32'(init), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_iflag"}, 32'(initial_flag), 32'd1);
        check({tag, "_wflag"}, 32'(weight_flag), 32'd1);
        check({tag, "_fire_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_qsize"}, 32'(exp_q.size()), 32'(TOTAL));
        for (int i = 0; i < TOTAL; i++) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_mem[i] = e;
                check($sformatf("%s_word[%0d]", tag, i), 32'(dut_word(i)), 32'(e));
            end
        end
        @(posedge clk);
        #1;
        check({tag, "_init_drop"}, 32'(init), 32'd0);
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_state_idle"}, 32'(state), 32'(S_IDLE));
    endtask

    initial begin
        int cyc;
        int init_before;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        for (int i = 0; i < TOTAL; i++) exp_mem[i] = '0;

        // 1: reset values
        repeat (3) @(posedge clk);
        #1;
        check_mem("rst_mem");
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_init", 32'(init), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state), 32'(S_IDLE));
        @(negedge clk) rst = 1'b0;

        // 2: full incrementing load, no bubbles
        begin_load(1'b0);
        stream(0, 8'h00, 0, 0, TOTAL, cyc);
        check("load_cycles", 32'(cyc), 32'd27);
        finish_check("inc");
        check("x0", 32'(x[0]), 32'h01);
        check("x1", 32'(x[1]), 32'h02);
        check("x2", 32'(x[2]), 32'h03);
        check("b00", 32'(b[0][0]), 32'h04);
        check("b02", 32'(b[0][2]), 32'h06);
        check("w000", 32'(w[0][0][0]), 32'h07);
        check("w022", 32'(w[0][2][2]), 32'h0F);
        check("b10", 32'(b[1][0]), 32'h10);
        check("w122", 32'(w[1][2][2]), 32'h1B);
        check("inc_pulses", 32'(init_cnt), 32'd1);

        // 1b: reset mid-simulation clears loaded arrays
        @(negedge clk) rst = 1'b1;
        #1;
        for (int i = 0; i < TOTAL; i++) exp_mem[i] = '0;
        check_mem("midrst_mem");
        check("midrst_ready", 32'(in_ready), 32'd0);
        @(negedge clk) rst = 1'b0;

        // 3: bubbles with constant 0.5, then in_valid during IDLE is ignored
        begin_load(1'b0);
        stream(1, 8'h10, 40, 0, TOTAL, cyc);
        finish_check("half");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h77;
            #1;
            check("idle_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk) in_valid = 1'b0;
        check_mem("idle_hold");

        // 4: negative values keep their sign bits
        begin_load(1'b0);
        stream(1, 8'hE0, 20, 0, TOTAL, cyc);
        finish_check("neg");
        check("neg_w111", 32'(w[1][1][1]), 32'hE0);

        // 5: reset after 10 transfers, then a clean reload
        init_before = init_cnt;
        begin_load(1'b0);
        stream(0, 8'h00, 0, 0, 10, cyc);
        @(negedge clk) rst = 1'b1;
        #1;
        exp_q.delete();
        for (int i = 0; i < TOTAL; i++) exp_mem[i] = '0;
        check_mem("abort_mem");
        check("abort_ready", 32'(in_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("abort_no_init", 32'(init_cnt), 32'(init_before));
        begin_load(1'b0);
        stream(0, 8'h00, 10, 0, TOTAL, cyc);
        finish_check("reload");

        // 6: start held high across LOAD/FIRE and into the following IDLE cycle
        init_before = init_cnt;
        begin_load(1'b1);
        stream(0, 8'h00, 0, 0, TOTAL, cyc);
        finish_check("hold1");
        @(posedge clk);
        #1;
        start = 1'b0;
        check("hold_relaunch", 32'(state), 32'(S_LOAD));
        check("hold_single_init", 32'(init_cnt), 32'(init_before + 1));
        stream(2, 8'h00, 0, 0, 4, cyc);
        check("mix_x0_new", 32'(x[0]), 32'h40);
        check("mix_b00_new", 32'(b[0][0]), 32'h43);
        check("mix_b01_old", 32'(b[0][1]), 32'h05);
        check("mix_w122_old", 32'(w[1][2][2]), 32'(exp_mem[26]));
        check("mix_no_init", 32'(init), 32'd0);
        stream(2, 8'h00, 15, 4, TOTAL - 4, cyc);
        finish_check("hold2");
        check("hold_two_inits", 32'(init_cnt), 32'(init_before + 2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
